// File: rtl/joypad_port.sv
// NES controller port ($4016/$4017) fed by PS/2 make/break events.
// Tracks eight held buttons and serves the strobe-then-shift serial read protocol.
module joypad_port #(
    parameter logic [7:0] KEY_A          = 8'h42,
    parameter logic [7:0] KEY_B          = 8'h3B,
    parameter logic [7:0] KEY_SEL        = 8'h59,
    parameter logic [7:0] KEY_START      = 8'h5A,
    parameter logic [7:0] KEY_UP         = 8'h1D,
    parameter logic [7:0] KEY_DOWN       = 8'h1B,
    parameter logic [7:0] KEY_LEFT       = 8'h1C,
    parameter logic [7:0] KEY_RIGHT      = 8'h23,
    parameter bit         BLOCK_OPPOSING = 1'b1
) (
    input  logic       clk,
    input  logic       nres,
    input  logic [7:0] keyCode,
    input  logic       press,
    input  logic       cpu_en,
    input  logic       cs,
    input  logic       addr0,
    input  logic       rw,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic [7:0] keystates
);

    logic [8:0] r_prev;
    logic [7:0] r_raw;
    logic [7:0] r_keys;
    logic       r_strobe;
    logic [7:0] r_shreg;

    logic       w_event;
    logic [7:0] w_raw_next;
    logic       w_wr_strobe;
    logic       w_rd_port1;
    logic       w_unused_data;

    // Pressing both directions of an axis is impossible on a real pad; report neither.
    function automatic logic [7:0] filter_opposing(input logic [7:0] raw);
        logic [7:0] f;
        f = raw;
        if (BLOCK_OPPOSING) begin
            if (raw[4] && raw[5]) begin
                f[5:4] = 2'b00;
            end else begin
                f[5:4] = raw[5:4];
            end
            if (raw[6] && raw[7]) begin
                f[7:6] = 2'b00;
            end else begin
                f[7:6] = raw[7:6];
            end
        end else begin
            f = raw;
        end
        return f;
    endfunction

    assign w_unused_data = ^data_in[7:1];
    assign w_event       = ({keyCode, press} != r_prev);
    assign w_wr_strobe   = cpu_en & cs & ~rw & ~addr0;
    assign w_rd_port1    = cpu_en & cs & rw & ~addr0;

    // Next raw button vector: only a changed {keyCode, press} pair touches a button.
    always_comb begin
        w_raw_next = r_raw;
        if (w_event) begin
            case (keyCode)
                KEY_A:     w_raw_next[0] = press;
                KEY_B:     w_raw_next[1] = press;
                KEY_SEL:   w_raw_next[2] = press;
                KEY_START: w_raw_next[3] = press;
                KEY_UP:    w_raw_next[4] = press;
                KEY_DOWN:  w_raw_next[5] = press;
                KEY_LEFT:  w_raw_next[6] = press;
                KEY_RIGHT: w_raw_next[7] = press;
                default:   w_raw_next = r_raw;
            endcase
        end else begin
            w_raw_next = r_raw;
        end
    end

    // Button state, strobe latch and serial shift register.
    always_ff @(posedge clk) begin
        if (!nres) begin
            r_prev   <= {keyCode, press};
            r_raw    <= 8'h00;
            r_keys   <= 8'h00;
            r_strobe <= 1'b0;
            r_shreg  <= 8'hFF;
        end else begin
            r_prev <= {keyCode, press};
            r_raw  <= w_raw_next;
            r_keys <= filter_opposing(w_raw_next);
            if (w_wr_strobe) begin
                r_strobe <= data_in[0];
            end else begin
                r_strobe <= r_strobe;
            end
            // Reload sees the current keystates, so a same-cycle key event lands one cycle later.
            if (r_strobe) begin
                r_shreg <= r_keys;
            end else if (w_rd_port1) begin
                r_shreg <= {1'b1, r_shreg[7:1]};
            end else begin
                r_shreg <= r_shreg;
            end
        end
    end

    // Read mux; upper bits mimic the $40 open-bus value.
    always_comb begin
        if (addr0) begin
            data_out = 8'h40;
        end else if (r_strobe) begin
            data_out = {7'b0100000, r_keys[0]};
        end else begin
            data_out = {7'b0100000, r_shreg[0]};
        end
    end

    assign keystates = r_keys;

endmodule
